fetch: RTL and testbench

//  Instruction-fetch stage of the pipelined LEGv8 core. Owns the fetch PC and

---
 rtl/fetch_if.sv | 17 +
 rtl/fetch.sv | 134 +++++++++++++
 tb/tb_fetch.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
//   req  : request valid (fetch -> imem)
//   addr : request address, held stable until acked (fetch -> imem)
//   ack  : response valid, may assert in the request cycle (imem -> fetch)
//   data : instruction word, valid with ack (imem -> fetch)
interface fetch_if #(
  parameter int unsigned WORDSIZE = 64,
  parameter int unsigned INSTSIZE = 32
);
  logic                req;
  logic [WORDSIZE-1:0] addr;
  logic                ack;
  logic [INSTSIZE-1:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage of the pipelined LEGv8 core.
// Owns the fetch PC, issues requests over the imem req/ack bus and presents
// {nop, pc, inst} to the IF/ID register. Handles variable-latency memory,
// an ID stall via a one-entry hold buffer, and taken-branch redirects that
// squash an in-flight response.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   stall    : ID hazard stall, IF/ID holds pc/inst while high
//   branch   : taken branch / redirect this cycle
//   target   : redirect address (bits [1:0] forced to zero)
//   imem     : instruction memory bus (master side)
//   nop      : registered bubble flag, downstream ignores pc/inst when 1
//   pc, inst : registered address and word of the presented instruction
module fetch #(
  parameter int unsigned         WORDSIZE  = 64,
  parameter int unsigned         INSTSIZE  = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC  = '0,
  parameter logic [WORDSIZE-1:0] INST_STEP = WORDSIZE'(4)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch,
  input  logic [WORDSIZE-1:0] target,
  fetch_if.master             imem,
  output logic                nop,
  output logic [WORDSIZE-1:0] pc,
  output logic [INSTSIZE-1:0] inst
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t              state;
  logic [WORDSIZE-1:0] reqpc;
  logic [WORDSIZE-1:0] tgt;
  logic [WORDSIZE-1:0] hold_pc;
  logic [INSTSIZE-1:0] hold_inst;

  logic [WORDSIZE-1:0] tgt_al;
  logic                advance;

  // Word-aligned redirect address.
  assign tgt_al  = target & ~WORDSIZE'(3);
  assign advance = !stall || branch;

  // Request is a pure decode of the state register; address is the fetch PC,
  // which only moves on ack or on a redirect outside DISCARD.
  assign imem.req  = (state == REQ) || (state == DISCARD);
  assign imem.addr = reqpc;

  // Fetch FSM with registered IF/ID outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      reqpc     <= RESET_PC;
      tgt       <= '0;
      hold_pc   <= '0;
      hold_inst <= '0;
      nop       <= 1'b1;
      pc        <= '0;
      inst      <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
        end

        REQ: begin
          if (branch) begin
            nop <= 1'b1;
            if (imem.ack) begin
              // Response for the wrong path is dropped; restart at target.
              reqpc <= tgt_al;
            end else begin
              // Keep the old address on the bus until its ack drains.
              tgt   <= tgt_al;
              state <= DISCARD;
            end
          end else if (imem.ack) begin
            reqpc <= reqpc + INST_STEP;
            if (!stall) begin
              nop  <= 1'b0;
              pc   <= reqpc;
              inst <= imem.data;
            end else begin
              hold_pc   <= reqpc;
              hold_inst <= imem.data;
              state     <= HOLD;
            end
          end else if (!stall) begin
            nop <= 1'b1;
          end
        end

        HOLD: begin
          if (branch) begin
            // Buffered instruction is on the wrong path; it is simply
            // abandoned and overwritten by the next stalled response.
            nop   <= 1'b1;
            reqpc <= tgt_al;
            state <= REQ;
          end else if (!stall) begin
            nop   <= 1'b0;
            pc    <= hold_pc;
            inst  <= hold_inst;
            state <= REQ;
          end
        end

        DISCARD: begin
          if (advance) begin
            nop <= 1'b1;
          end
          if (imem.ack) begin
            reqpc <= branch ? tgt_al : tgt;
            state <= REQ;
          end else if (branch) begin
            tgt <= tgt_al;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage: a per-cycle vector table plus a
// hand-written reset-during-wait sequence, against a latency-programmable
// instruction memory model.
module tb_fetch;
  localparam int unsigned W = 64;
  localparam int unsigned I = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         branch;
  logic [W-1:0] target;
  logic         nop;
  logic [W-1:0] pc;
  logic [I-1:0] inst;

  always #5 clk = ~clk;

  fetch_if #(.WORDSIZE(W), .INSTSIZE(I)) imem ();

  fetch #(.WORDSIZE(W), .INSTSIZE(I), .RESET_PC('0), .INST_STEP(W'(4))) dut (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .branch (branch),
    .target (target),
    .imem   (imem.master),
    .nop    (nop),
    .pc     (pc),
    .inst   (inst)
  );

  // Memory model: ack in the acyc-th cycle of a request (1 = same cycle).
  int   acyc;
  int   cnt;
  logic force_ack;

  function automatic logic [I-1:0] mem_word(input logic [W-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  assign imem.ack  = force_ack | (imem.req && (cnt == acyc - 1));
  assign imem.data = mem_word(imem.addr);

  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 0;
    else if (!imem.req || imem.ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  typedef struct {
    logic         stall;
    logic         branch;
    logic [W-1:0] target;
    int           acyc;
    logic         req;
    logic [W-1:0] addr;
    logic         nop;
    logic [W-1:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic b, input logic [W-1:0] t, input int a,
                              input logic rq, input logic [W-1:0] ad, input logic n,
                              input logic [W-1:0] p);
    vec_t v;
    v.stall = s; v.branch = b; v.target = t; v.acyc = a;
    v.req = rq; v.addr = ad; v.nop = n; v.pc = p;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;
    rst = 1'b1; stall = 1'b0; branch = 1'b0; target = '0; acyc = 1; force_ack = 1'b0;

    // stall branch target acyc | req addr (this cycle) | nop pc (after edge)
    add(0, 0, 0, 1,   0, 0, 1, 0);                 // IDLE
    add(0, 0, 0, 1,   1, 0, 0, 0);                 // same-cycle ack stream
    add(0, 0, 0, 1,   1, 4, 0, 4);
    add(0, 0, 0, 1,   1, 8, 0, 8);
    add(0, 0, 0, 1,   1, 12, 0, 12);
    add(0, 0, 0, 3,   1, 16, 1, 12);               // 3-cycle memory
    add(0, 0, 0, 3,   1, 16, 1, 12);
    add(0, 0, 0, 3,   1, 16, 0, 16);
    add(0, 0, 0, 3,   1, 20, 1, 16);
    add(0, 0, 0, 3,   1, 20, 1, 16);
    add(0, 0, 0, 3,   1, 20, 0, 20);
    add(1, 0, 0, 1,   1, 24, 0, 20);               // ack under stall -> HOLD
    add(1, 0, 0, 1,   0, 28, 0, 20);
    add(1, 0, 0, 1,   0, 28, 0, 20);
    add(1, 0, 0, 1,   0, 28, 0, 20);
    add(0, 0, 0, 1,   0, 28, 0, 24);               // buffered pc emitted once
    add(0, 0, 0, 1,   1, 28, 0, 28);
    add(0, 1, 'h103, 3, 1, 'h20, 1, 28);           // redirect, req outstanding
    add(0, 0, 0, 3,   1, 'h20, 1, 28);
    add(0, 0, 0, 3,   1, 'h20, 1, 28);             // old ack dropped
    add(0, 0, 0, 1,   1, 'h100, 0, 'h100);
    add(0, 0, 0, 1,   1, 'h104, 0, 'h104);
    add(1, 0, 0, 1,   1, 'h108, 0, 'h104);         // -> HOLD with 0x108
    add(1, 1, 'h200, 1, 0, 'h10c, 1, 'h104);       // branch+stall in HOLD
    add(0, 0, 0, 1,   1, 'h200, 0, 'h200);
    add(0, 0, 0, 1,   1, 'h204, 0, 'h204);
    add(0, 1, 'h302, 1, 1, 'h208, 1, 'h204);       // branch with same-cycle ack
    add(0, 0, 0, 1,   1, 'h300, 0, 'h300);
    add(0, 1, '1, 1,  1, 'h304, 1, 'h300);         // redirect near top of space
    add(0, 0, 0, 1,   1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'hFFFF_FFFF_FFFF_FFFC);
    add(0, 0, 0, 1,   1, 0, 0, 0);                 // PC wrapped
    add(0, 1, 'h400, 3, 1, 4, 1, 0);               // DISCARD, latest target wins
    add(0, 1, 'h500, 3, 1, 4, 1, 0);
    add(0, 0, 0, 3,   1, 4, 1, 0);
    add(0, 0, 0, 1,   1, 'h500, 0, 'h500);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("rst nop", W'(nop), 1);
    check("rst pc", pc, 0);
    check("rst inst", W'(inst), 0);
    check("rst req", W'(imem.req), 0);
    check("rst addr", imem.addr, 0);

    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < vecs.size(); k++) begin
      stall = vecs[k].stall; branch = vecs[k].branch;
      target = vecs[k].target; acyc = vecs[k].acyc;
      #1;
      check($sformatf("v%0d req", k), W'(imem.req), W'(vecs[k].req));
      check($sformatf("v%0d addr", k), imem.addr, vecs[k].addr);
      @(posedge clk); #1;
      check($sformatf("v%0d nop", k), W'(nop), W'(vecs[k].nop));
      check($sformatf("v%0d pc", k), pc, vecs[k].pc);
      if (!vecs[k].nop) check($sformatf("v%0d inst", k), W'(inst), W'(mem_word(vecs[k].pc)));
      @(negedge clk);
    end
    stall = 1'b0; branch = 1'b0; target = '0;

    // Reset pulse while a slow request is pending, then a late ack
    acyc = 8;
    #1;
    check("t6 req", W'(imem.req), 1);
    check("t6 addr", imem.addr, 'h504);
    @(posedge clk); #1;
    check("t6 bubble", W'(nop), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6 async nop", W'(nop), 1);
    check("t6 async pc", pc, 0);
    check("t6 async inst", W'(inst), 0);
    check("t6 async req", W'(imem.req), 0);
    force_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6 idle req", W'(imem.req), 0);
    @(posedge clk); #1;
    check("t6 idle ack nop", W'(nop), 1);
    check("t6 idle ack pc", pc, 0);
    @(negedge clk);
    force_ack = 1'b0;
    acyc = 1;
    #1;
    check("t6 restart addr", imem.addr, 0);
    n = 0;
    while (n < 10) begin
      @(posedge clk); #1;
      if (!nop) break;
      n++;
    end
    check("t6 restart nop", W'(nop), 0);
    check("t6 restart latency", W'(n), 0);
    check("t6 restart pc", pc, 0);
    check("t6 restart inst", W'(inst), W'(mem_word(0)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
